// File: rtl/spi_ram_cmd_ctrl.sv
// spi_ram_cmd_ctrl: command-decoding RAM controller that sits behind the SPI slave.
// It takes 10-bit frames ({opcode, payload}) and uses them to set the write and read
// addresses, write data, or start a read. Read data is returned on dout/tx_valid and
// held for TX_HOLD cycles so the slave can shift it out.
module spi_ram_cmd_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = 10,
    parameter int AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       addr_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_LAT = 2'd1,
        TX     = 2'd2
    } state_t;

    localparam logic [1:0]           OP_WR_ADDR = 2'b00;
    localparam logic [1:0]           OP_WR_DATA = 2'b01;
    localparam logic [1:0]           OP_RD_ADDR = 2'b10;
    localparam logic [1:0]           OP_RD_DATA = 2'b11;
    localparam logic [ADDR_SIZE:0]   DEPTH_W    = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE:0]   LAST_W     = (ADDR_SIZE+1)'(MEM_DEPTH - 1);
    localparam logic [7:0]           HOLD_M1    = 8'(TX_HOLD - 1);

    state_t                 state_q, state_d;
    logic                   rx_valid_q;
    logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_SIZE-1:0]   rd_cap_q, rd_cap_d;
    logic [7:0]             dout_q, dout_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   addr_err_q, addr_err_d;
    logic [7:0]             cnt_q, cnt_d;

    logic                   cmd_stb;
    logic [1:0]             op;
    logic [ADDR_SIZE-1:0]   payload;
    logic                   mem_we;
    logic                   wr_in_range;
    logic                   rd_in_range;
    logic                   cap_in_range;
    logic [7:0]             rd_word;

    logic [7:0]             mem [MEM_DEPTH];

    // Post-increment with wrap to zero after the last implemented word.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if ({1'b0, a} == LAST_W) begin
            return '0;
        end
        return a + ADDR_SIZE'(1);
    endfunction

    assign cmd_stb      = rx_valid & ~rx_valid_q;
    assign op           = din[9:8];
    assign payload      = din[ADDR_SIZE-1:0];
    assign wr_in_range  = ({1'b0, wr_addr_q} < DEPTH_W);
    assign rd_in_range  = ({1'b0, rd_addr_q} < DEPTH_W);
    assign cap_in_range = ({1'b0, rd_cap_q} < DEPTH_W);

    // Asynchronous memory read of the address captured when the read was issued.
    always_comb begin
        rd_word = mem[rd_cap_q];
    end

    // Command decode plus read/transmit FSM next-state and output logic.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_cap_d   = rd_cap_q;
        dout_d     = dout_q;
        tx_valid_d = tx_valid_q;
        addr_err_d = 1'b0;
        cnt_d      = cnt_q;
        mem_we     = 1'b0;

        if (cmd_stb) begin
            unique case (op)
                OP_WR_ADDR: wr_addr_d = payload;
                OP_WR_DATA: begin
                    if (wr_in_range) begin
                        mem_we = 1'b1;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    if (AUTO_INC != 0) begin
                        wr_addr_d = next_addr(wr_addr_q);
                    end
                end
                OP_RD_ADDR: rd_addr_d = payload;
                OP_RD_DATA: begin
                    rd_cap_d = rd_addr_q;
                    if (!rd_in_range) begin
                        addr_err_d = 1'b1;
                    end
                    if (AUTO_INC != 0) begin
                        rd_addr_d = next_addr(rd_addr_q);
                    end
                end
                default: ;
            endcase
        end

        // Any strobe while a read is in flight cancels it; op 11 starts a fresh one.
        unique case (state_q)
            IDLE: begin
                if (cmd_stb && op == OP_RD_DATA) begin
                    state_d = RD_LAT;
                end
            end
            RD_LAT: begin
                if (cmd_stb) begin
                    tx_valid_d = 1'b0;
                    state_d    = (op == OP_RD_DATA) ? RD_LAT : IDLE;
                end else begin
                    dout_d     = cap_in_range ? rd_word : 8'h00;
                    tx_valid_d = 1'b1;
                    cnt_d      = HOLD_M1;
                    state_d    = TX;
                end
            end
            TX: begin
                if (cmd_stb) begin
                    tx_valid_d = 1'b0;
                    state_d    = (op == OP_RD_DATA) ? RD_LAT : IDLE;
                end else if (cnt_q == 8'd0) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // Control and datapath registers, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rx_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rd_cap_q   <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= rx_valid;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            rd_cap_q   <= rd_cap_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            addr_err_q <= addr_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Memory array write port; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= din[7:0];
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign addr_err = addr_err_q;

endmodule
